uart_rx_param: RTL

Parametrised UART receiver. Successor to the fixed 8N1 receiver: configurable data width, parity and stop bits, with a double-flop input synchronizer and 3-sample majority voting. Adds false-start rejection, parity/framing/break detection, and a valid/ready output with overrun reporting. Sits between the serial pin and any byte consumer, such as a FIFO or command parser.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rx_sync.sv | 44 ++++
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity mode
// constants, the receive FSM state type and a width helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BRK_WAIT
   } rx_state_t;

   // $clog2 clamped to at least 1 so derived vector widths are never zero
   function automatic int clog2_safe(input int value);
      int result;
      result = $clog2(value);
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the serial pin: two-flop synchronizer, a 3-deep
// history of the synchronized line and its majority vote. Everything
// resets to 1 so the line looks idle until real data arrives.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic rx,
   output logic synced,
   output logic sample
);

   logic [1:0] sync_chain;
   logic [2:0] history;

   // two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_chain <= 2'b11;
      end else begin
         sync_chain <= {sync_chain[0], rx};
      end
   end

   // shift register of the last three synchronized values for voting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         history <= 3'b111;
      end else begin
         history <= {history[1:0], sync_chain[1]};
      end
   end

   assign synced = sync_chain[1];

   // 2-of-3 majority: a single-cycle glitch can never flip the vote
   always_comb begin
      sample = (history[0] & history[1]) |
               (history[0] & history[2]) |
               (history[1] & history[2]);
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop
// bits, false-start rejection, parity/framing/break detection and a
// valid/ready output holding register with overrun reporting.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
)
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_frame_err,
   output logic                 m_parity_err,
   output logic                 m_break,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = clog2_safe(CLKS_PER_BIT);
   localparam int BW = clog2_safe(DATA_BITS);
   localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   rx_state_t            state;
   logic [CW-1:0]        count;
   logic [BW-1:0]        bit_index;
   logic                 stop_index;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;
   logic                 frame_err;

   logic synced;
   logic sample;

   logic data_par;
   logic par_err_now;
   logic frame_now;
   logic brk_now;

   uart_rx_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .rx      (rx),
      .synced  (synced),
      .sample  (sample)
   );

   // frame status as it will stand once the current stop sample is taken
   always_comb begin
      data_par    = (^shreg) ^ par_bit;
      par_err_now = 1'b0;
      if (PARITY == PAR_ODD) begin
         par_err_now = ~data_par;
      end else if (PARITY == PAR_EVEN) begin
         par_err_now = data_par;
      end
      frame_now = frame_err | ~sample;
      brk_now   = frame_now && (shreg == '0) && !par_bit;
   end

   assign busy = (state != ST_IDLE);

   // receive FSM with bit timing, deserializer and output holding register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         count        <= '0;
         bit_index    <= '0;
         stop_index   <= 1'b0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         frame_err    <= 1'b0;
         m_data       <= '0;
         m_frame_err  <= 1'b0;
         m_parity_err <= 1'b0;
         m_break      <= 1'b0;
         m_valid      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!synced) begin
                  state <= ST_START;
                  count <= '0;
               end
            end

            ST_START: begin
               if (count == HALF) begin
                  count <= '0;
                  if (sample) begin
                     // line went back high before mid-bit: noise, not a start
                     state <= ST_IDLE;
                  end else begin
                     state      <= ST_DATA;
                     bit_index  <= '0;
                     stop_index <= 1'b0;
                     par_bit    <= 1'b0;
                     frame_err  <= 1'b0;
                  end
               end else begin
                  count <= count + CW'(1);
               end
            end

            ST_DATA: begin
               if (count == LAST) begin
                  count            <= '0;
                  shreg[bit_index] <= sample;
                  if (bit_index == BIT_LAST) begin
                     state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_index <= bit_index + BW'(1);
                  end
               end else begin
                  count <= count + CW'(1);
               end
            end

            ST_PARITY: begin
               if (count == LAST) begin
                  count   <= '0;
                  par_bit <= sample;
                  state   <= ST_STOP;
               end else begin
                  count <= count + CW'(1);
               end
            end

            ST_STOP: begin
               if (count == LAST) begin
                  count <= '0;
                  if (stop_index == STOP_LAST) begin
                     // a slot is free if empty or being consumed this cycle
                     if (!m_valid || m_ready) begin
                        m_data       <= shreg;
                        m_frame_err  <= frame_now;
                        m_parity_err <= par_err_now;
                        m_break      <= brk_now;
                        m_valid      <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                     // a low stop bit means the line may stay low; wait it out
                     state <= sample ? ST_IDLE : ST_BRK_WAIT;
                  end else begin
                     stop_index <= 1'b1;
                     frame_err  <= frame_now;
                  end
               end else begin
                  count <= count + CW'(1);
               end
            end

            ST_BRK_WAIT: begin
               if (synced) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
